// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin over WIDTH bits, DIGIT bits per clock,
// with a start/busy/done handshake and borrow, zero and signed-overflow flags.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Zero,
  output logic             Ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             busy_q, done_q, bout_q, zero_q, ovf_q;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
  logic             dig_bmsb;
  logic [WIDTH-1:0] res_d;

  // Ripple-borrow subtraction of the lowest DIGIT operand bits; dig_bmsb is the
  // borrow entering the top bit of the digit, which is the operand MSB on the last step.
  always_comb begin
    logic br;
    br       = borrow_q;
    dig_diff = '0;
    dig_bmsb = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dig_bmsb    = br;
      dig_diff[i] = a_q[i] ^ b_q[i] ^ br;
      br          = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
    end
    dig_bout = br;
  end

  // New digit enters the result register from the MSB end.
  assign res_d = (res_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          res_q    <= res_d;
          borrow_q <= dig_bout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= dig_bout;
            zero_q  <= (res_d == '0);
            ovf_q   <= dig_bmsb ^ dig_bout;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = bout_q;
  assign Zero   = zero_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor for W=8 (D=1,2,4,8) and W=16 (D=4).
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        bin_in;

  logic       busy8[4], done8[4], borrow8[4], zero8[4], ovf8[4];
  logic [7:0] diff8[4];
  logic        busy16, done16, borrow16, zero16, ovf16;
  logic [15:0] diff16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_w8
    serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst(rst), .Start(start),
      .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
      .Busy(busy8[g]), .Done(done8[g]), .Diff(diff8[g]),
      .Borrow(borrow8[g]), .Zero(zero8[g]), .Ovf(ovf8[g])
    );
  end

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .Start(start),
    .A(a_in), .B(b_in), .Bin(bin_in),
    .Busy(busy16), .Done(done16), .Diff(diff16),
    .Borrow(borrow16), .Zero(zero16), .Ovf(ovf16)
  );

  // Index 0..3 selects the 8-bit instance with DIGIT = 1<<g, index 4 the 16-bit one.
  function automatic logic busy_sel(input int g);
    return (g == 4) ? busy16 : busy8[g[1:0]];
  endfunction
  function automatic logic done_sel(input int g);
    return (g == 4) ? done16 : done8[g[1:0]];
  endfunction
  function automatic logic borrow_sel(input int g);
    return (g == 4) ? borrow16 : borrow8[g[1:0]];
  endfunction
  function automatic logic zero_sel(input int g);
    return (g == 4) ? zero16 : zero8[g[1:0]];
  endfunction
  function automatic logic ovf_sel(input int g);
    return (g == 4) ? ovf16 : ovf8[g[1:0]];
  endfunction
  function automatic logic [15:0] diff_sel(input int g);
    return (g == 4) ? diff16 : {8'h00, diff8[g[1:0]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation on instance g; at busy cycle 'poke' (if > 0) a new Start with
  // different operands is pulsed and must be ignored.
  task automatic op(input int g, input logic [15:0] a_raw, input logic [15:0] b_raw,
                    input logic bin, input int poke, input string tag);
    int          w, steps, nb, wd, sa, sb, s;
    logic [15:0] mask, a, b, ediff;
    logic        eb, ez, eo;
    w     = (g == 4) ? 16 : 8;
    steps = (g == 4) ? 4 : (8 >> g);
    mask  = 16'((1 << w) - 1);
    a     = a_raw & mask;
    b     = b_raw & mask;
    ediff = 16'(int'(a) - int'(b) - int'(bin)) & mask;
    eb    = (int'(a) < int'(b) + int'(bin));
    ez    = (ediff == 16'h0000);
    sa    = a[w-1] ? int'(a) - (1 << w) : int'(a);
    sb    = b[w-1] ? int'(b) - (1 << w) : int'(b);
    s     = sa - sb - int'(bin);
    eo    = (s < -(1 << (w - 1))) || (s >= (1 << (w - 1)));

    a_in = a_raw; b_in = b_raw; bin_in = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; wd = 0;
    while (!done_sel(g) && wd < 40) begin
      if (busy_sel(g)) nb++;
      if (poke > 0) begin
        start = (nb == poke);
        if (nb == poke) begin
          a_in = ~a_raw; b_in = a_raw; bin_in = ~bin;
        end
      end
      @(negedge clk);
      wd++;
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 32'(nb), 32'(steps));
    chk({tag, " done"}, 32'(done_sel(g)), 32'd1);
    chk({tag, " busy at done"}, 32'(busy_sel(g)), 32'd0);
    chk({tag, " diff"}, 32'(diff_sel(g)), 32'(ediff));
    chk({tag, " borrow"}, 32'(borrow_sel(g)), 32'(eb));
    chk({tag, " zero"}, 32'(zero_sel(g)), 32'(ez));
    chk({tag, " ovf"}, 32'(ovf_sel(g)), 32'(eo));
    @(negedge clk);
    chk({tag, " done pulse width"}, 32'(done_sel(g)), 32'd0);
  endtask

  initial begin
    int wd, nd;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy8[0]), 32'd0);
    chk("reset done", 32'(done8[0]), 32'd0);
    chk("reset diff", 32'(diff8[0]), 32'd0);
    chk("reset borrow", 32'(borrow8[0]), 32'd0);
    chk("reset zero", 32'(zero8[0]), 32'd0);
    chk("reset ovf", 32'(ovf8[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(0, 16'h0005, 16'h0003, 1'b0, 0, "basic");
    chk("basic diff hand", 32'(diff8[0]), 32'h02);
    op(0, 16'h0003, 16'h0005, 1'b0, 0, "underflow");
    chk("underflow diff hand", 32'(diff8[0]), 32'hFE);
    chk("underflow borrow hand", 32'(borrow8[0]), 32'd1);
    op(0, 16'h0000, 16'h0000, 1'b1, 0, "bin only");
    chk("bin only diff hand", 32'(diff8[0]), 32'hFF);
    chk("bin only borrow hand", 32'(borrow8[0]), 32'd1);
    op(0, 16'h0080, 16'h0001, 1'b0, 0, "sovf");
    chk("sovf diff hand", 32'(diff8[0]), 32'h7F);
    chk("sovf ovf hand", 32'(ovf8[0]), 32'd1);
    op(0, 16'h005A, 16'h005A, 1'b0, 0, "zero");
    chk("zero flag hand", 32'(zero8[0]), 32'd1);
    op(0, 16'h0010, 16'h0001, 1'b0, 3, "midstart");
    chk("midstart diff hand", 32'(diff8[0]), 32'h0F);
    chk("midstart idle after", 32'(busy8[0]), 32'd0);

    // Start held high through DONE: next operation follows without an IDLE cycle.
    a_in = 16'h0020; b_in = 16'h0010; bin_in = 1'b0; start = 1'b1;
    wd = 0;
    while (!done8[0] && wd < 40) begin @(negedge clk); wd++; end
    chk("b2b first done", 32'(done8[0]), 32'd1);
    chk("b2b first diff", 32'(diff8[0]), 32'h10);
    a_in = 16'h0030; b_in = 16'h0031;
    @(negedge clk);
    chk("b2b busy no idle", 32'(busy8[0]), 32'd1);
    chk("b2b done drops", 32'(done8[0]), 32'd0);
    wd = 1;
    while (!done8[0] && wd < 40) begin @(negedge clk); wd++; end
    chk("b2b done period", 32'(wd), 32'd9);
    chk("b2b second diff", 32'(diff8[0]), 32'hFF);
    chk("b2b second borrow", 32'(borrow8[0]), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b end done", 32'(done8[0]), 32'd0);
    chk("b2b end busy", 32'(busy8[0]), 32'd0);

    // Asynchronous reset in the middle of an operation.
    a_in = 16'h0044; b_in = 16'h0011; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy8[0]), 32'd0);
    chk("midrst done", 32'(done8[0]), 32'd0);
    chk("midrst diff", 32'(diff8[0]), 32'd0);
    chk("midrst borrow", 32'(borrow8[0]), 32'd0);
    chk("midrst zero", 32'(zero8[0]), 32'd0);
    chk("midrst ovf", 32'(ovf8[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8[0]) nd++;
    end
    chk("midrst no done", 32'(nd), 32'd0);
    chk("midrst idle busy", 32'(busy8[0]), 32'd0);
    op(0, 16'h0044, 16'h0011, 1'b0, 0, "after rst");
    chk("after rst diff hand", 32'(diff8[0]), 32'h33);

    // Digit sweep: directed then random operands on every configuration.
    op(1, 16'h00A5, 16'h005A, 1'b1, 0, "w8d2");
    chk("w8d2 diff hand", 32'(diff8[1]), 32'h4A);
    op(2, 16'h0001, 16'h0080, 1'b0, 0, "w8d4");
    chk("w8d4 diff hand", 32'(diff8[2]), 32'h81);
    chk("w8d4 ovf hand", 32'(ovf8[2]), 32'd1);
    op(3, 16'h007F, 16'h00FF, 1'b0, 0, "w8d8");
    chk("w8d8 diff hand", 32'(diff8[3]), 32'h80);
    chk("w8d8 ovf hand", 32'(ovf8[3]), 32'd1);
    op(4, 16'h1234, 16'h1235, 1'b1, 0, "w16d4");
    chk("w16d4 diff hand", 32'(diff16), 32'hFFFE);
    chk("w16d4 borrow hand", 32'(borrow16), 32'd1);
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 200; i++) begin
        op(g, 16'($urandom), 16'($urandom), 1'($urandom), 0, $sformatf("rnd g%0d #%0d", g, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
